health_bar_ctrl: RTL and testbench

//   Control stage that drives the W-bit bidirectional shift register holding one

---
 rtl/health_bar_ctrl.sv | 135 +++++++++++++
 tb/tb_health_bar_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/health_bar_ctrl.sv
// Control stage for one fighter's thermometer-coded health bar shift register.
// Turns round-start, hit and heal events into load/ctrl/serial strobes and tracks HP.
module health_bar_ctrl #(
    parameter int unsigned W          = 8,
    parameter int unsigned DW         = 3,
    parameter int unsigned INV_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     round_start,
    input  logic                     hit,
    input  logic [DW-1:0]            hit_dmg,
    input  logic                     heal,
    output logic [1:0]               ctrl,
    output logic                     serial_in_right,
    output logic                     serial_in_left,
    output logic                     load,
    output logic [W-1:0]             parallel_in,
    output logic [$clog2(W+1)-1:0]   hp,
    output logic                     busy,
    output logic                     ko
);

    localparam int unsigned HW = $clog2(W + 1);
    localparam int unsigned IW = $clog2(INV_CYCLES + 1);
    localparam int unsigned CW = (DW > HW) ? DW : HW;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAlive,
        StHeal,
        StDamage,
        StInvuln,
        StKo
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hp_q, hp_d;
    logic [HW-1:0]   rem_q, rem_d;
    logic [IW-1:0]   inv_q, inv_d;
    logic [HW-1:0]   dmg_clamped;

    assign serial_in_right = 1'b0;
    assign serial_in_left  = 1'b1;
    assign parallel_in     = {W{1'b1}};
    assign hp              = hp_q;

    // Compare at the wider of the two widths so neither operand is truncated.
    assign dmg_clamped = (CW'(hit_dmg) > CW'(hp_q)) ? hp_q : HW'(hit_dmg);

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        rem_d   = rem_q;
        inv_d   = inv_q;
        ctrl    = 2'b00;
        load    = 1'b0;
        busy    = 1'b0;
        ko      = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StLoad: begin
                load    = 1'b1;
                busy    = 1'b1;
                hp_d    = HW'(W);
                state_d = StAlive;
            end
            StAlive: begin
                if (hit && (hit_dmg != '0)) begin
                    rem_d   = dmg_clamped;
                    state_d = StDamage;
                end else if (heal && !hit && (hp_q != HW'(W))) begin
                    state_d = StHeal;
                end
            end
            StHeal: begin
                ctrl    = 2'b10;
                hp_d    = hp_q + HW'(1);
                state_d = StAlive;
            end
            StDamage: begin
                ctrl  = 2'b01;
                busy  = 1'b1;
                hp_d  = hp_q - HW'(1);
                rem_d = rem_q - HW'(1);
                if (rem_q == HW'(1)) begin
                    if (hp_q == HW'(1)) begin
                        state_d = StKo;
                    end else begin
                        inv_d   = IW'(INV_CYCLES);
                        state_d = StInvuln;
                    end
                end
            end
            StInvuln: begin
                busy  = 1'b1;
                inv_d = inv_q - IW'(1);
                if (inv_q == IW'(1)) begin
                    state_d = StAlive;
                end
            end
            StKo: begin
                ko = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // hp keeps following any shift issued this cycle, so it still matches the bar.
        if (round_start) begin
            state_d = StLoad;
            rem_d   = '0;
            inv_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hp_q    <= '0;
            rem_q   <= '0;
            inv_q   <= '0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            rem_q   <= rem_d;
            inv_q   <= inv_d;
        end
    end

endmodule

// File: tb/tb_health_bar_ctrl.sv
// Bench for health_bar_ctrl: directed scenarios plus randomized events checked against
// an event-level model of the round, with a model of the downstream shift register.
module tb_health_bar_ctrl;

    localparam int W   = 8;
    localparam int DW  = 3;
    localparam int INV = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          round_start = 1'b0;
    logic          hit = 1'b0;
    logic [DW-1:0] hit_dmg = '0;
    logic          heal = 1'b0;
    logic [1:0]    ctrl;
    logic          serial_in_right;
    logic          serial_in_left;
    logic          load;
    logic [W-1:0]  parallel_in;
    logic [3:0]    hp;
    logic          busy;
    logic          ko;

    health_bar_ctrl #(
        .W          (W),
        .DW         (DW),
        .INV_CYCLES (INV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .round_start     (round_start),
        .hit             (hit),
        .hit_dmg         (hit_dmg),
        .heal            (heal),
        .ctrl            (ctrl),
        .serial_in_right (serial_in_right),
        .serial_in_left  (serial_in_left),
        .load            (load),
        .parallel_in     (parallel_in),
        .hp              (hp),
        .busy            (busy),
        .ko              (ko)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Round model: pending load, shifts still owed, heal pending, invulnerability left.
    int   m_load, m_alive, m_ko, m_heal, m_shifts, m_inv, m_hp;
    logic [W-1:0] bar;

    function automatic logic [1:0] exp_ctrl();
        if (m_shifts > 0) return 2'b01;
        if (m_heal != 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic exp_busy();
        return (m_load != 0) || (m_shifts > 0) || (m_inv > 0);
    endfunction

    function automatic logic [W-1:0] therm(input int n);
        return W'((1 << n) - 1);
    endfunction

    task automatic model_step(input logic r, input logic rs, input logic h,
                              input logic [DW-1:0] d, input logic hl);
        if (r) begin
            m_load = 0; m_alive = 0; m_ko = 0; m_heal = 0; m_shifts = 0; m_inv = 0; m_hp = 0;
        end else begin
            // HP follows whatever the bar physically does this cycle.
            if (m_shifts > 0) m_hp = m_hp - 1;
            else if (m_heal != 0) m_hp = m_hp + 1;
            else if (m_load != 0) m_hp = W;

            if (rs) begin
                m_load = 1; m_alive = 0; m_ko = 0; m_heal = 0; m_shifts = 0; m_inv = 0;
            end else if (m_load != 0) begin
                m_load = 0; m_alive = 1;
            end else if (m_shifts > 0) begin
                m_shifts = m_shifts - 1;
                if (m_shifts == 0) begin
                    if (m_hp == 0) begin
                        m_ko = 1; m_alive = 0;
                    end else begin
                        m_inv = INV;
                    end
                end
            end else if (m_heal != 0) begin
                m_heal = 0;
            end else if (m_inv > 0) begin
                m_inv = m_inv - 1;
            end else if (m_alive != 0) begin
                if (h && (d != 0)) m_shifts = (int'(d) > m_hp) ? m_hp : int'(d);
                else if (hl && !h && (m_hp < W)) m_heal = 1;
            end
        end
    endtask

    // One clock: drive inputs, advance model and bar, return at the next falling edge.
    task automatic cycle(input logic r, input logic rs, input logic h,
                         input logic [DW-1:0] d, input logic hl);
        logic [1:0] c;
        logic       l;
        c = ctrl;
        l = load;
        rst = r; round_start = rs; hit = h; hit_dmg = d; heal = hl;
        @(posedge clk);
        #1;
        model_step(r, rs, h, d, hl);
        if (r) bar = '0;
        else if (l) bar = {W{1'b1}};
        else if (c == 2'b01) bar = {1'b0, bar[W-1:1]};
        else if (c == 2'b10) bar = {bar[W-2:0], 1'b1};
        rst = 1'b0; round_start = 1'b0; hit = 1'b0; hit_dmg = '0; heal = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic start_round();
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(1);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tests++;
        if ({ctrl, load, busy, ko, hp} !== 9'b0) begin
            fails++;
            $display("FAIL reset_outputs: ctrl=%b load=%b busy=%b ko=%b hp=%0d, need all 0",
                     ctrl, load, busy, ko, hp);
        end
        tests++;
        if ({serial_in_right, serial_in_left, parallel_in} !== {2'b01, 8'hFF}) begin
            fail_consts();
        end
    endtask

    task automatic fail_consts();
        fails++;
        $display("FAIL const_outputs: sir=%b sil=%b pin=%h, need 0 1 ff",
                 serial_in_right, serial_in_left, parallel_in);
    endtask

    task automatic test_load();
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tests++;
        if (load !== 1'b1 || ctrl !== 2'b00 || busy !== 1'b1) begin
            fails++;
            $display("FAIL load_cycle: load=%b ctrl=%b busy=%b, need 1 00 1", load, ctrl, busy);
        end
        idle(1);
        tests++;
        if (load !== 1'b0 || hp !== 4'd8 || bar !== 8'hFF) begin
            fails++;
            $display("FAIL load_done: load=%b hp=%0d bar=%h, need 0 8 ff", load, hp, bar);
        end
    endtask

    task automatic test_damage();
        int n01 = 0;
        int nbusy = 0;
        start_round();
        cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (ctrl === 2'b01) n01++;
            if (busy === 1'b1) nbusy++;
            idle(1);
        end
        tests++;
        if (n01 != 3 || nbusy != 7) begin
            fails++;
            $display("FAIL damage_timing: shifts=%0d busy=%0d, need 3 7", n01, nbusy);
        end
        tests++;
        if (bar !== 8'h1F || hp !== 4'd5 || busy !== 1'b0) begin
            fails++;
            $display("FAIL damage_result: bar=%h hp=%0d busy=%b, need 1f 5 0", bar, hp, busy);
        end
    endtask

    task automatic test_ko();
        int n01 = 0;
        int nact = 0;
        start_round();
        cycle(1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        idle(12);
        tests++;
        if (hp !== 4'd2) begin
            fails++;
            $display("FAIL ko_setup: hp=%0d, need 2", hp);
        end
        cycle(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (ctrl === 2'b01) n01++;
            idle(1);
        end
        tests++;
        if (n01 != 2 || hp !== 4'd0 || bar !== 8'h00 || ko !== 1'b1) begin
            fails++;
            $display("FAIL ko_clamp: shifts=%0d hp=%0d bar=%h ko=%b, need 2 0 00 1",
                     n01, hp, bar, ko);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
            if (ctrl !== 2'b00 || ko !== 1'b1) nact++;
        end
        tests++;
        if (nact != 0 || hp !== 4'd0) begin
            fails++;
            $display("FAIL ko_hold: bad_cycles=%0d hp=%0d, need 0 0", nact, hp);
        end
    endtask

    task automatic test_heal();
        int n10 = 0;
        start_round();
        cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        idle(10);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        tests++;
        if (ctrl !== 2'b10 || busy !== 1'b0) begin
            fails++;
            $display("FAIL heal_ctrl: ctrl=%b busy=%b, need 10 0", ctrl, busy);
        end
        idle(1);
        tests++;
        if (ctrl !== 2'b00 || hp !== 4'd6 || bar !== 8'h3F) begin
            fails++;
            $display("FAIL heal_result: ctrl=%b hp=%0d bar=%h, need 00 6 3f", ctrl, hp, bar);
        end
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
            if (ctrl === 2'b10) n10++;
        end
        tests++;
        if (n10 != 0 || hp !== 4'd8 || bar !== 8'hFF) begin
            fail_heal_full(n10);
        end
    endtask

    task automatic fail_heal_full(input int n10);
        fails++;
        $display("FAIL heal_full: heal_shifts=%0d hp=%0d bar=%h, need 0 8 ff", n10, hp, bar);
    endtask

    task automatic test_hit_heal();
        int n01 = 0;
        int n10 = 0;
        start_round();
        cycle(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        idle(10);
        cycle(1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
        if (ctrl === 2'b01) n01++;
        if (ctrl === 2'b10) n10++;
        idle(1);
        cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (ctrl === 2'b01) n01++;
            if (ctrl === 2'b10) n10++;
            idle(1);
        end
        tests++;
        if (n01 != 1 || n10 != 0 || hp !== 4'd5 || bar !== 8'h1F) begin
            fails++;
            $display("FAIL hit_heal_invuln: r=%0d l=%0d hp=%0d bar=%h, need 1 0 5 1f",
                     n01, n10, hp, bar);
        end
    endtask

    task automatic test_abort();
        int n01 = 0;
        start_round();
        cycle(1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        if (ctrl === 2'b01) n01++;
        idle(1);
        if (ctrl === 2'b01) n01++;
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tests++;
        if (load !== 1'b1 || ctrl !== 2'b00 || n01 != 2) begin
            fails++;
            $display("FAIL abort_load: load=%b ctrl=%b shifts=%0d, need 1 00 2", load, ctrl, n01);
        end
        idle(1);
        tests++;
        if (hp !== 4'd8 || bar !== 8'hFF || ctrl !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_refill: hp=%0d bar=%h ctrl=%b busy=%b, need 8 ff 00 0",
                     hp, bar, ctrl, busy);
        end
    endtask

    task automatic test_random();
        logic r, rs, h, hl;
        logic [DW-1:0] d;
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 39) == 0);
            h  = ($urandom_range(0, 4) == 0);
            hl = ($urandom_range(0, 3) == 0);
            d  = DW'($urandom_range(0, 7));
            cycle(r, rs, h, d, hl);
            tests++;
            if (ctrl !== exp_ctrl() || load !== (m_load != 0) || busy !== exp_busy() ||
                ko !== (m_ko != 0) || hp !== 4'(m_hp) || bar !== therm(m_hp)) begin
                fails++;
                $display("FAIL random[%0d]: ctrl=%b load=%b busy=%b ko=%b hp=%0d bar=%h, need %b %0d %b %0d %0d %h",
                         i, ctrl, load, busy, ko, hp, bar, exp_ctrl(), m_load, exp_busy(),
                         m_ko, m_hp, therm(m_hp));
            end
            tests++;
            if (ctrl === 2'b11 || (load === 1'b1 && ctrl !== 2'b00)) begin
                fails++;
                $display("FAIL random_illegal[%0d]: ctrl=%b load=%b, need ctrl!=11 and no load with shift",
                         i, ctrl, load);
            end
        end
    endtask

    initial begin
        bar = '0;
        m_load = 0; m_alive = 0; m_ko = 0; m_heal = 0; m_shifts = 0; m_inv = 0; m_hp = 0;
        @(negedge clk);
        test_reset();
        test_load();
        test_damage();
        test_ko();
        test_heal();
        test_hit_heal();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
